// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch front end.
//   sw_state_t    : IDLE / RUN / PAUSE control states
//   SW_CLK_HZ     : default system clock frequency
//   SW_TICK_HZ    : default tick rate (100 Hz -> 10 ms ticks)
//   CLR_PULSE_CYC : width of the active-low clear pulse, in clk cycles
package stopwatch_pkg;

   typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_PAUSE} sw_state_t;

   localparam int SW_CLK_HZ     = 50_000_000;
   localparam int SW_TICK_HZ    = 100;
   localparam int CLR_PULSE_CYC = 2;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces one active-low push-button.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   key_raw   : raw button level, asynchronous to clk (0 = pressed)
//   key_level : debounced level (1 = released)
//   key_press : one-cycle pulse on the debounced 1->0 transition
// The debounced level follows the synced level once it has disagreed with
// it for DEB_CYC+1 consecutive samples; any agreeing sample restarts the
// count. After reset the key must be seen released before it can count,
// so a button held through reset produces no event.
module key_debounce #(
   parameter int DEB_CYC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_level,
   output logic key_press
);

   localparam int             CW      = $clog2(DEB_CYC + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYC);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;

   always_comb begin
      sync1_d = key_raw;
      sync2_d = sync1_q;
      // Synchronizer resets to "pressed", so a 1 here is a genuine release.
      armed_d = armed_q | sync2_q;
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (armed_q && (sync2_q != level_q)) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            press_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b1;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign key_level = level_q;
   assign key_press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button debouncing, IDLE/RUN/PAUSE control and 100 Hz
// tick generation for the stopwatch.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   key_start : raw start/stop button, active-low
//   key_clr   : raw clear button, active-low
//   key_lap   : raw lap button, active-low (STOPWATCH_LAP_EN only)
//   cnt_10ms  : one-cycle tick every TICK_DIV RUN cycles
//   cnt_rst   : active-low clear for downstream counters
//   running   : high while in RUN
//   lap_hold  : display freeze request (STOPWATCH_LAP_EN only)
// Build option: define STOPWATCH_LAP_EN to add the lap button and lap_hold.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = SW_CLK_HZ,
   parameter int TICK_HZ = SW_TICK_HZ,
   parameter int DEB_MS  = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic key_start,
   input  logic key_clr,
`ifdef STOPWATCH_LAP_EN
   input  logic key_lap,
   output logic lap_hold,
`endif
   output logic cnt_10ms,
   output logic cnt_rst,
   output logic running
);

   localparam int             TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int             DEB_CYC  = CLK_HZ / 1000 * DEB_MS;
   localparam int             DW       = $clog2(TICK_DIV);
   localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);
   localparam int             CRW      = $clog2(CLR_PULSE_CYC + 1);

   logic start_ev, clr_ev;
   logic start_level_unused, clr_level_unused;

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
      .clk(clk), .rst(rst), .key_raw(key_start),
      .key_level(start_level_unused), .key_press(start_ev));

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (
      .clk(clk), .rst(rst), .key_raw(key_clr),
      .key_level(clr_level_unused), .key_press(clr_ev));

`ifdef STOPWATCH_LAP_EN
   logic lap_ev, lap_level_unused;
   logic lap_q, lap_d;

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_lap (
      .clk(clk), .rst(rst), .key_raw(key_lap),
      .key_level(lap_level_unused), .key_press(lap_ev));
`endif

   sw_state_t      state_q, state_d;
   logic [DW-1:0]  div_q, div_d;
   logic [CRW-1:0] clr_cnt_q, clr_cnt_d;
   logic           tick_q, tick_d;
   logic           cnt_rst_q, cnt_rst_d;
   logic           running_q, running_d;

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      tick_d    = 1'b0;
      clr_cnt_d = (clr_cnt_q != '0) ? clr_cnt_q - CRW'(1) : '0;
`ifdef STOPWATCH_LAP_EN
      lap_d     = lap_q;
`endif
      if (clr_ev) begin
         // Clear overrides a coincident start event.
         state_d   = SW_IDLE;
         div_d     = '0;
         clr_cnt_d = CRW'(CLR_PULSE_CYC - 1);
`ifdef STOPWATCH_LAP_EN
         lap_d     = 1'b0;
`endif
      end else begin
         // Divider only moves in RUN; PAUSE keeps the sub-tick phase.
         if (state_q == SW_RUN) begin
            div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
            tick_d = (div_q == DIV_LAST);
         end
         if (start_ev) begin
            case (state_q)
               SW_IDLE:  state_d = SW_RUN;
               SW_RUN:   state_d = SW_PAUSE;
               SW_PAUSE: state_d = SW_RUN;
               default:  state_d = SW_IDLE;
            endcase
         end
`ifdef STOPWATCH_LAP_EN
         if (lap_ev && (state_q == SW_RUN))
            lap_d = ~lap_q;
`endif
      end
      // Low in the event cycle plus the remaining stretch cycles.
      cnt_rst_d = ~(clr_ev | (clr_cnt_q != '0));
      tick_d    = tick_d & cnt_rst_d;
      running_d = (state_d == SW_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= SW_IDLE;
         div_q     <= '0;
         clr_cnt_q <= '0;
         tick_q    <= 1'b0;
         cnt_rst_q <= 1'b0;
         running_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         clr_cnt_q <= clr_cnt_d;
         tick_q    <= tick_d;
         cnt_rst_q <= cnt_rst_d;
         running_q <= running_d;
`ifdef STOPWATCH_LAP_EN
         lap_q     <= lap_d;
`endif
      end
   end

   assign cnt_10ms = tick_q;
   assign cnt_rst  = cnt_rst_q;
   assign running  = running_q;
`ifdef STOPWATCH_LAP_EN
   assign lap_hold = lap_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100, DEB_MS=2
// (TICK_DIV=10, DEB_CYC=2). Directed scenarios with literal expectations,
// followed by randomized button activity; a behavioural model is compared
// against every output on every cycle.
module tb_stopwatch_ctrl;

   localparam int TD  = 10;
   localparam int DEB = 2;
   localparam int CLR = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic key_start = 1'b1;
   logic key_clr   = 1'b1;
   logic key_lap   = 1'b1;
   logic cnt_10ms, cnt_rst, running;
`ifdef STOPWATCH_LAP_EN
   logic lap_hold;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DEB_MS(2)) dut (
      .clk(clk), .rst(rst), .key_start(key_start), .key_clr(key_clr),
`ifdef STOPWATCH_LAP_EN
      .key_lap(key_lap), .lap_hold(lap_hold),
`endif
      .cnt_10ms(cnt_10ms), .cnt_rst(cnt_rst), .running(running));

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // st: 0 idle, 1 run, 2 pause; acc = RUN cycles since last tick;
   // rem = clear-pulse cycles still to output.
   int st = 0, acc = 0, rem = 0;
   bit m_tick = 0, m_crst = 0, m_run = 0, m_lap = 0;
   // Per key: h1/h2 = raw level one/two edges ago, runl = consecutive
   // samples disagreeing with the debounced level.
   bit armed [3];
   bit lvl   [3];
   bit press [3];
   bit h1    [3];
   bit h2    [3];
   int hv    [3];
   int runl  [3];

   always @(posedge clk) begin
      bit rk [3];
      rk[0] = key_start; rk[1] = key_clr; rk[2] = key_lap;
      cyc++;
      if (!rst) begin
         st = 0; acc = 0; rem = 0;
         m_tick = 0; m_crst = 0; m_run = 0; m_lap = 0;
         for (int k = 0; k < 3; k++) begin
            armed[k] = 0; lvl[k] = 1; press[k] = 0; hv[k] = 0; runl[k] = 0;
         end
      end else begin
         m_tick = 0;
         if (press[1]) begin
            st = 0; acc = 0; m_lap = 0; rem = CLR;
         end else begin
`ifdef STOPWATCH_LAP_EN
            if (press[2] && st == 1) m_lap = !m_lap;
`endif
            if (st == 1) begin
               acc++;
               if (acc == TD) begin m_tick = 1; acc = 0; end
            end
            if (press[0]) st = (st == 1) ? 2 : 1;
         end
         if (rem > 0) begin m_crst = 0; rem--; end
         else m_crst = 1;
         if (!m_crst) m_tick = 0;
         m_run = (st == 1);
         for (int k = 0; k < 3; k++) begin
            press[k] = 0;
            if (hv[k] >= 2) begin
               if (!armed[k]) armed[k] = h2[k];
               else if (h2[k] != lvl[k]) begin
                  runl[k]++;
                  if (runl[k] == DEB + 1) begin
                     lvl[k] = h2[k]; press[k] = !h2[k]; runl[k] = 0;
                  end
               end else runl[k] = 0;
            end
            h2[k] = h1[k]; h1[k] = rk[k];
            if (hv[k] < 2) hv[k]++;
         end
      end
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("cnt_10ms", cnt_10ms, m_tick);
      chk("cnt_rst", cnt_rst, m_crst);
      chk("running", running, m_run);
`ifdef STOPWATCH_LAP_EN
      chk("lap_hold", lap_hold, m_lap);
`endif
   end

   // ---------------- directed helpers ----------------
   task automatic lit(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic wait_run(input logic val, input int lim, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (running !== val && n < lim);
      if (running !== val) n = -1;
   endtask

   task automatic wait_tick(input int lim, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (cnt_10ms !== 1'b1 && n < lim);
      if (cnt_10ms !== 1'b1) n = -1;
   endtask

   task automatic count_ticks(input int len, output int c);
      c = 0;
      repeat (len) begin @(negedge clk); if (cnt_10ms === 1'b1) c++; end
   endtask

   task automatic tap(input int k, input int hold);
      if (k == 0) key_start = 0; else if (k == 1) key_clr = 0; else key_lap = 0;
      repeat (hold) @(negedge clk);
      key_start = 1; key_clr = 1; key_lap = 1;
      repeat (8) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, c, t, low;
      logic prev;
      int dur [3];
      bit lv [3];

      // Reset
      repeat (3) @(negedge clk);
      lit("reset_cnt_rst", cnt_rst, 0);
      lit("reset_running", running, 0);
      rst = 1;
      @(negedge clk);
      lit("post_reset_cnt_rst", cnt_rst, 1);
      count_ticks(50, c);
      lit("idle_ticks", c, 0);

      // Start: event 5 cycles after the raw edge, running one later
      key_start = 0;
      wait_run(1, 30, n);
      lit("start_latency", n, 6);
      key_start = 1;
      wait_tick(20, n);
      lit("first_tick", n, 10);
      count_ticks(50, c);
      lit("run_ticks_50", c, 5);

      // Pause lands 4 RUN cycles after the next tick
      repeat (8) @(negedge clk);
      key_start = 0;
      wait_run(0, 30, n);
      lit("pause_latency", n, 6);
      key_start = 1;
      count_ticks(100, c);
      lit("pause_ticks", c, 0);
      key_start = 0;
      wait_run(1, 30, n);
      key_start = 1;
      wait_tick(20, n);
      lit("resume_tick", n, 6);

      // Bounce: 1-cycle glitches then a held press -> exactly one event
      for (int i = 0; i < 10; i++) begin key_start = i[0]; @(negedge clk); end
      key_start = 0;
      t = 0; prev = running;
      repeat (30) begin
         @(negedge clk);
         if (running !== prev) t++;
         prev = running;
      end
      lit("bounce_events", t, 1);
      lit("bounce_paused", running, 0);
      key_start = 1;
      repeat (10) @(negedge clk);

      // Clear during RUN
      key_start = 0; wait_run(1, 30, n); key_start = 1;
      repeat (15) @(negedge clk);
      key_clr = 0; low = 0;
      repeat (20) begin @(negedge clk); if (cnt_rst === 1'b0) low++; end
      lit("clr_width", low, 2);
      lit("clr_running", running, 0);
      key_clr = 1;
      count_ticks(50, c);
      lit("clr_ticks", c, 0);

      // Start and clear together from IDLE: clear wins
      key_start = 0; key_clr = 0;
      repeat (20) @(negedge clk);
      lit("simul_idle", running, 0);
      key_start = 1; key_clr = 1;
      repeat (10) @(negedge clk);

`ifdef STOPWATCH_LAP_EN
      key_start = 0; wait_run(1, 30, n); key_start = 1;
      repeat (5) @(negedge clk);
      key_lap = 0; repeat (8) @(negedge clk);
      lit("lap_set", lap_hold, 1);
      key_lap = 1;
      count_ticks(30, c);
      lit("lap_ticks", c, 3);
      tap(2, 8);
      lit("lap_clear", lap_hold, 0);
      tap(2, 8);
      lit("lap_set_again", lap_hold, 1);
      key_start = 0; wait_run(0, 30, n); key_start = 1;
      repeat (8) @(negedge clk);
      tap(2, 8);
      lit("lap_in_pause", lap_hold, 1);
      tap(1, 8);
      lit("lap_cleared", lap_hold, 0);
`endif

      // Key held through reset gives no event until re-pressed
      key_start = 0; rst = 0;
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (20) @(negedge clk);
      lit("held_through_reset", running, 0);
      key_start = 1;
      repeat (10) @(negedge clk);
      key_start = 0;
      wait_run(1, 30, n);
      lit("press_after_reset", n, 6);
      key_start = 1;
      repeat (10) @(negedge clk);

      // Randomized activity, checked cycle by cycle against the model
      for (int k = 0; k < 3; k++) begin dur[k] = 0; lv[k] = 1; end
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (dur[k] == 0) begin
               if (!lv[k] || k != 1 || $urandom_range(0, 5) == 0) lv[k] = !lv[k];
               dur[k] = $urandom_range(1, 14);
            end else dur[k]--;
         end
         key_start = lv[0]; key_clr = lv[1]; key_lap = lv[2];
         rst = ($urandom_range(0, 399) != 0);
      end
      @(negedge clk);
      key_start = 1; key_clr = 1; key_lap = 1; rst = 1;
      repeat (30) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
